// File: rtl/conv_mac_kernel.sv
// rtl/conv_mac_kernel.sv - pipelined fixed-point MAC convolution kernel with bias, ReLU and rounding
// Define CONV_SAT_EN to saturate the narrowed result instead of two's-complement wrapping.
module conv_mac_kernel #(
  parameter int DATA_WIDTH  = 16,
  parameter int FRAC_BITS   = 8,
  parameter int KERNEL_TAPS = 9
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          i_clear,
  input  logic                          i_valid,
  input  logic [DATA_WIDTH-1:0]         i_pixel,
  input  logic [DATA_WIDTH-1:0]         i_weight,
  input  logic [DATA_WIDTH-1:0]         i_bias,
  input  logic                          i_relu,
  output logic                          o_valid,
  output logic [DATA_WIDTH-1:0]         o_pixel,
  output logic [$clog2(KERNEL_TAPS):0]  o_tap_cnt
);
  localparam int ACC_WIDTH  = 2*DATA_WIDTH + $clog2(KERNEL_TAPS) + 1;
  localparam int CNT_WIDTH  = $clog2(KERNEL_TAPS) + 1;
  localparam int PROD_WIDTH = 2*DATA_WIDTH;
  // Half an output LSB; evaluates to zero when there are no fractional bits.
  localparam logic signed [ACC_WIDTH-1:0] RND = ACC_WIDTH'((2**FRAC_BITS)/2);

  logic                          accept, tap_first, tap_last;
  logic signed [PROD_WIDTH-1:0]  prod;

  logic                          s1_valid, s1_first, s1_last, s1_relu;
  logic signed [PROD_WIDTH-1:0]  s1_prod;
  logic signed [DATA_WIDTH-1:0]  s1_bias;

  logic                          s2_last, s2_relu;
  logic signed [ACC_WIDTH-1:0]   acc;

  logic signed [ACC_WIDTH-1:0]   prod_ext, bias_ext, r_shift, r_relu;
  logic [DATA_WIDTH-1:0]         result;

  assign accept    = i_valid && !i_clear;
  assign tap_first = (o_tap_cnt == '0);
  assign tap_last  = (o_tap_cnt == CNT_WIDTH'(KERNEL_TAPS-1));
  assign prod      = PROD_WIDTH'($signed(i_pixel)) * PROD_WIDTH'($signed(i_weight));
  assign prod_ext  = ACC_WIDTH'(s1_prod);
  assign bias_ext  = ACC_WIDTH'(s1_bias) <<< FRAC_BITS;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      o_tap_cnt <= '0;
    end else if (i_clear) begin
      o_tap_cnt <= '0;
    end else if (i_valid) begin
      o_tap_cnt <= tap_last ? '0 : o_tap_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_first <= 1'b0;
      s1_last  <= 1'b0;
      s1_relu  <= 1'b0;
      s1_prod  <= '0;
      s1_bias  <= '0;
    end else begin
      s1_valid <= accept;
      s1_last  <= accept && tap_last;
      if (accept) begin
        s1_first <= tap_first;
        s1_prod  <= prod;
        s1_bias  <= $signed(i_bias);
        s1_relu  <= i_relu;
      end
    end
  end

  // The first tap reseeds the accumulator, so abutting windows need no bubble.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc     <= '0;
      s2_last <= 1'b0;
      s2_relu <= 1'b0;
    end else begin
      s2_last <= !i_clear && s1_valid && s1_last;
      if (s1_valid) begin
        acc <= s1_first ? (bias_ext + prod_ext) : (acc + prod_ext);
        if (s1_last)
          s2_relu <= s1_relu;
      end
    end
  end

  always_comb begin
    r_shift = (acc + RND) >>> FRAC_BITS;
    r_relu  = (s2_relu && r_shift[ACC_WIDTH-1]) ? '0 : r_shift;
    result  = r_relu[DATA_WIDTH-1:0];
  end

`ifdef CONV_SAT_EN
  localparam logic signed [ACC_WIDTH-1:0] SAT_MAX =
    {{(ACC_WIDTH-DATA_WIDTH+1){1'b0}}, {(DATA_WIDTH-1){1'b1}}};
  localparam logic signed [ACC_WIDTH-1:0] SAT_MIN =
    {{(ACC_WIDTH-DATA_WIDTH+1){1'b1}}, {(DATA_WIDTH-1){1'b0}}};
  logic [DATA_WIDTH-1:0] narrowed;

  always_comb begin
    narrowed = result;
    if (r_relu > SAT_MAX)
      narrowed = DATA_WIDTH'(SAT_MAX);
    else if (r_relu < SAT_MIN)
      narrowed = DATA_WIDTH'(SAT_MIN);
  end
`else
  logic [DATA_WIDTH-1:0] narrowed;
  logic                  unused_r_hi;

  assign narrowed    = result;
  assign unused_r_hi = ^r_relu[ACC_WIDTH-1:DATA_WIDTH];
`endif

  // Stage 3 is not gated by i_clear: a result already past the accumulator still lands.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      o_valid <= 1'b0;
      o_pixel <= '0;
    end else begin
      o_valid <= s2_last;
      if (s2_last)
        o_pixel <= narrowed;
    end
  end

endmodule

// File: tb/tb_conv_mac_kernel.sv
// tb/tb_conv_mac_kernel.sv - self-checking bench for conv_mac_kernel
// Honours CONV_SAT_EN the same way as the design.
module tb_conv_mac_kernel;
  localparam int DW = 16;
  localparam int FB = 8;
  localparam int KT = 9;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              i_clear = 1'b0;
  logic              i_valid = 1'b0;
  logic [DW-1:0]     i_pixel = '0;
  logic [DW-1:0]     i_weight = '0;
  logic [DW-1:0]     i_bias = '0;
  logic              i_relu = 1'b0;
  logic              o_valid;
  logic [DW-1:0]     o_pixel;
  logic [$clog2(KT):0] o_tap_cnt;

  int tests = 0;
  int fails = 0;
  int cyc = 0;

  logic [DW-1:0] got_q[$];
  int            got_cyc[$];
  logic [DW-1:0] exp_q[$];
  int            exp_cyc[$];
  logic [DW-1:0] px[KT];
  logic [DW-1:0] wt[KT];

  conv_mac_kernel #(.DATA_WIDTH(DW), .FRAC_BITS(FB), .KERNEL_TAPS(KT)) dut (
    .clk(clk), .rst_n(rst_n), .i_clear(i_clear), .i_valid(i_valid),
    .i_pixel(i_pixel), .i_weight(i_weight), .i_bias(i_bias), .i_relu(i_relu),
    .o_valid(o_valid), .o_pixel(o_pixel), .o_tap_cnt(o_tap_cnt)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (o_valid) begin
      got_q.push_back(o_pixel);
      got_cyc.push_back(cyc);
    end
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Reference: exact sum, round half-up, ReLU, then saturate or wrap.
  function automatic logic [DW-1:0] model(input longint acc, input bit relu);
    longint r;
    longint maxv;
    longint minv;
    maxv = (longint'(1) <<< (DW-1)) - 1;
    minv = -(longint'(1) <<< (DW-1));
    r = (acc + ((longint'(1) <<< FB) / 2)) >>> FB;
    if (relu && r < 0) r = 0;
`ifdef CONV_SAT_EN
    if (r > maxv) r = maxv;
    else if (r < minv) r = minv;
`else
    if (maxv < minv) r = 0;
`endif
    return r[DW-1:0];
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    i_valid = 1'b0;
    repeat (n) tick();
  endtask

  task automatic tap(input logic [DW-1:0] p, input logic [DW-1:0] w,
                     input logic [DW-1:0] b, input bit r);
    i_valid  = 1'b1;
    i_pixel  = p;
    i_weight = w;
    i_bias   = b;
    i_relu   = r;
    tick();
    i_valid  = 1'b0;
  endtask

  // gap < 0: random 0..2 idle cycles before each tap; exp_lit < 0: use the model.
  task automatic window(input logic [DW-1:0] bias, input bit relu, input int gap,
                        input bit chk_cnt, input int exp_lit);
    longint acc;
    acc = longint'($signed(bias)) <<< FB;
    for (int t = 0; t < KT; t++) begin
      if (gap < 0) idle($urandom_range(2, 0));
      else if (gap > 0) idle(gap);
      acc += longint'($signed(px[t])) * longint'($signed(wt[t]));
      tap(px[t], wt[t], (t == 0) ? bias : DW'($urandom), (t == KT-1) ? relu : 1'($urandom));
      if (chk_cnt) check("tap_cnt", 64'(o_tap_cnt), 64'((t + 1) % KT));
    end
    if (exp_lit >= 0) exp_q.push_back(DW'(exp_lit));
    else exp_q.push_back(model(acc, relu));
    exp_cyc.push_back(cyc + 2);
  endtask

  task automatic drain(input string tag);
    int n;
    idle(5);
    check({tag, "_count"}, 64'(got_q.size()), 64'(exp_q.size()));
    n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
    for (int k = 0; k < n; k++) begin
      check({tag, "_pixel"}, 64'(got_q[k]), 64'(exp_q[k]));
      check({tag, "_cycle"}, 64'(got_cyc[k]), 64'(exp_cyc[k]));
    end
    got_q.delete();
    got_cyc.delete();
    exp_q.delete();
    exp_cyc.delete();
  endtask

  task automatic fill(input logic [DW-1:0] p, input logic [DW-1:0] w);
    for (int t = 0; t < KT; t++) begin
      px[t] = p;
      wt[t] = w;
    end
  endtask

  initial begin
    repeat (3) tick();
    check("rst_valid", 64'(o_valid), 64'(0));
    check("rst_pixel", 64'(o_pixel), 64'(0));
    check("rst_cnt", 64'(o_tap_cnt), 64'(0));
    rst_n = 1'b1;
    idle(2);
    check("idle_valid", 64'(got_q.size()), 64'(0));

    fill(16'h0080, 16'h0080);
    window(16'h0000, 1'b0, 0, 1'b1, 16'h0240);
    drain("half_sq");

    for (int t = 0; t < KT; t++) begin
      px[t] = DW'((t + 1) << 8);
      wt[t] = (t < KT-1) ? DW'((t + 2) << 8) : 16'h0100;
    end
`ifdef CONV_SAT_EN
    window(16'h0000, 1'b0, 0, 1'b0, 16'h7FFF);
`else
    window(16'h0000, 1'b0, 0, 1'b0, 16'hF900);
`endif
    drain("big_sum");

    fill(16'hFF00, 16'h0100);
    window(16'h0000, 1'b0, 0, 1'b0, 16'hF700);
    window(16'h0000, 1'b1, 0, 1'b0, 16'h0000);
    window(16'h0A00, 1'b0, 0, 1'b0, 16'h0100);
    drain("neg_relu_bias");

    fill(16'h0001, 16'h0080);
    window(16'h0000, 1'b0, 1, 1'b0, 16'h0005);
    drain("round");

    fill(16'h0100, 16'h0100);
    for (int t = 0; t < 4; t++) tap(px[t], wt[t], 16'h0000, 1'b0);
    check("pre_clear_cnt", 64'(o_tap_cnt), 64'(4));
    i_clear = 1'b1;
    tap(16'h0100, 16'h0100, 16'h0000, 1'b0);
    i_clear = 1'b0;
    check("clear_cnt", 64'(o_tap_cnt), 64'(0));
    fill(16'h0080, 16'h0080);
    window(16'h0000, 1'b0, 1, 1'b1, 16'h0240);
    drain("clear");

    fill(16'h0080, 16'h0080);
    window(16'h0000, 1'b0, 0, 1'b0, 16'h0240);
    fill(16'h0100, 16'h0100);
    window(16'h0000, 1'b0, 0, 1'b0, 16'h0900);
    fill(16'hFF00, 16'h0100);
    window(16'h0000, 1'b0, 0, 1'b0, 16'hF700);
    drain("abut");

    for (int w = 0; w < 24; w++) begin
      for (int t = 0; t < KT; t++) begin
        px[t] = (w % 3 == 0) ? DW'($urandom) : DW'($signed(10'($urandom)));
        wt[t] = (w % 3 == 0) ? DW'($urandom) : DW'($signed(10'($urandom)));
      end
      window(DW'($urandom), 1'($urandom), (w % 2 == 0) ? 0 : -1, 1'b1, -1);
    end
    drain("random");

    fill(16'h0100, 16'h0100);
    for (int t = 0; t < 5; t++) tap(px[t], wt[t], 16'h0000, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    check("amid_rst_valid", 64'(o_valid), 64'(0));
    check("amid_rst_pixel", 64'(o_pixel), 64'(0));
    check("amid_rst_cnt", 64'(o_tap_cnt), 64'(0));
    tick();
    rst_n = 1'b1;
    idle(1);
    fill(16'h0080, 16'h0080);
    window(16'h0000, 1'b0, 0, 1'b1, 16'h0240);
    drain("after_rst");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
